// File: rtl/lf_add64_seq.sv
// lf_add64_seq: 64-bit add/subtract computed over four beats on one shared
// 16-bit parallel-prefix (g,p) slice, least significant chunk first.
// Operands are captured at accept time.
// The result register is updated only when the last beat completes, so
// partial sums are never visible on sum.
module lf_add64_seq #(
   parameter int SUB_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        cin,
   input  logic        sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] sum,
   output logic        cout,
   output logic        ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [1:0]  beat_r;
   logic        carry_r;
   logic [63:0] a_r;
   logic [63:0] b_r;
   logic [47:0] acc_r;
   logic [63:0] sum_r;
   logic        cout_r;
   logic        ovf_r;

   logic        sub_eff_s;
   logic        accept_s;
   logic        in_ready_s;
   logic        out_valid_s;
   logic [15:0] a_chunk_s;
   logic [15:0] b_chunk_s;
   logic [17:0] slice_s;

   // 16-bit Kogge-Stone slice. The carry-in is folded into the bit-0
   // generate term so every prefix output is a true carry.
   // Returns {carry out of bit 15, carry into bit 15, 16-bit sum}.
   function automatic logic [17:0] slice_add(input logic [15:0] x,
                                             input logic [15:0] y,
                                             input logic        ci);
      logic [15:0] g;
      logic [15:0] p;
      logic [15:0] gg;
      logic [15:0] pp;
      logic [15:0] gn;
      logic [15:0] pn;
      logic [16:0] c;
      int          d;
      g     = x & y;
      p     = x ^ y;
      gg    = g;
      gg[0] = g[0] | (p[0] & ci);
      pp    = p;
      for (int lvl = 0; lvl < 4; lvl++) begin
         d  = 32'sd1 << lvl;
         gn = gg;
         pn = pp;
         for (int i = 0; i < 16; i++) begin
            gn[i] = (i >= d) ? (gg[i] | (pp[i] & gg[i-d])) : gg[i];
            pn[i] = (i >= d) ? (pp[i] & pp[i-d]) : pp[i];
         end
         gg = gn;
         pp = pn;
      end
      c[0]    = ci;
      c[16:1] = gg;
      return {c[16], c[15], p ^ c[15:0]};
   endfunction

   assign sub_eff_s = (SUB_EN != 0) ? sub : 1'b0;
   assign accept_s  = in_valid & in_ready_s;
   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_s;
   assign sum       = sum_r;
   assign cout      = cout_r;
   assign ovf       = ovf_r;

   // State register: asynchronous reset forces IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic: an accept in DONE chains straight into CALC.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = CALC;
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            if (beat_r == 2'd3) begin
               state_s = DONE;
            end else begin
               state_s = CALC;
            end
         end
         DONE: begin
            if (accept_s) begin
               state_s = CALC;
            end else if (out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state register.
   // in_ready is held low while reset is applied.
   always_comb begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      case (state_r)
         IDLE: begin
            in_ready_s = ~rst;
         end
         CALC: begin
            in_ready_s = 1'b0;
         end
         DONE: begin
            out_valid_s = 1'b1;
            in_ready_s  = out_ready & ~rst;
         end
         default: begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
         end
      endcase
   end

   // Chunk selection feeding the shared slice.
   always_comb begin
      a_chunk_s = 16'd0;
      b_chunk_s = 16'd0;
      case (beat_r)
         2'd0: begin
            a_chunk_s = a_r[15:0];
            b_chunk_s = b_r[15:0];
         end
         2'd1: begin
            a_chunk_s = a_r[31:16];
            b_chunk_s = b_r[31:16];
         end
         2'd2: begin
            a_chunk_s = a_r[47:32];
            b_chunk_s = b_r[47:32];
         end
         default: begin
            a_chunk_s = a_r[63:48];
            b_chunk_s = b_r[63:48];
         end
      endcase
   end

   assign slice_s = slice_add(a_chunk_s, b_chunk_s, carry_r);

   // Operand capture, per-beat accumulation and final result update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_r  <= 2'd0;
         carry_r <= 1'b0;
         a_r     <= 64'd0;
         b_r     <= 64'd0;
         acc_r   <= 48'd0;
         sum_r   <= 64'd0;
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
      end else if (accept_s) begin
         a_r     <= a;
         b_r     <= sub_eff_s ? ~b : b;
         carry_r <= sub_eff_s ? 1'b1 : cin;
         beat_r  <= 2'd0;
      end else if (state_r == CALC) begin
         carry_r <= slice_s[17];
         beat_r  <= beat_r + 2'd1;
         case (beat_r)
            2'd0: acc_r[15:0]  <= slice_s[15:0];
            2'd1: acc_r[31:16] <= slice_s[15:0];
            2'd2: acc_r[47:32] <= slice_s[15:0];
            default: begin
               sum_r  <= {slice_s[15:0], acc_r};
               cout_r <= slice_s[17];
               ovf_r  <= slice_s[17] ^ slice_s[16];
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lf_add64_seq.sv
// Testbench for lf_add64_seq: table-driven vectors plus hand-written
// back-pressure, back-to-back, reset-abort and operand-change sequences.
// A second instance with SUB_EN = 0 runs in lockstep on the same stimulus.
module tb_lf_add64_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_ready0;
   logic [63:0] a;
   logic [63:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_valid0;
   logic        out_ready;
   logic [63:0] sum;
   logic [63:0] sum0;
   logic        cout;
   logic        cout0;
   logic        ovf;
   logic        ovf0;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic        sub;
      logic [63:0] exp_sum;
      logic        exp_cout;
      logic        exp_ovf;
   } vec_t;

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
      logic [63:0] sum0;
      logic        cout0;
      logic        ovf0;
   } exp_t;

   vec_t        vecs[9];
   exp_t        sb_q[$];
   logic [63:0] prev_sum;
   logic [63:0] prev_sum0;

   lf_add64_seq #(.SUB_EN(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   lf_add64_seq #(.SUB_EN(0)) dut_nosub (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid0),
      .out_ready(out_ready), .sum(sum0), .cout(cout0), .ovf(ovf0)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Reference arithmetic: returns {ovf, cout, sum}.
   function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y,
                                         input logic ci, input logic s);
      logic [63:0] yy;
      logic        cc;
      logic [64:0] r;
      logic        v;
      yy = s ? ~y : y;
      cc = s ? 1'b1 : ci;
      r  = {1'b0, x} + {1'b0, yy} + {64'd0, cc};
      v  = (x[63] == yy[63]) && (r[63] != x[63]);
      return {v, r};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present an operation; expects the block to accept on the next edge.
   task automatic start_op(input logic [63:0] x, input logic [63:0] y, input logic ci,
                           input logic s, input logic [63:0] es, input logic ec,
                           input logic eo);
      exp_t        e;
      logic [65:0] m0;
      a        = x;
      b        = y;
      cin      = ci;
      sub      = s;
      in_valid = 1'b1;
      #1;
      chk("in_ready_at_accept", {63'd0, in_ready}, 64'd1);
      m0      = model(x, y, ci, 1'b0);
      e.sum   = es;
      e.cout  = ec;
      e.ovf   = eo;
      e.sum0  = m0[63:0];
      e.cout0 = m0[64];
      e.ovf0  = m0[65];
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   // Three CALC cycles with scrambled operands, then the edge that reaches DONE.
   task automatic wait_calc();
      for (int i = 0; i < 3; i++) begin
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         cin = 1'($urandom_range(0, 1));
         sub = 1'($urandom_range(0, 1));
         chk("calc_out_valid", {63'd0, out_valid}, 64'd0);
         chk("calc_in_ready", {63'd0, in_ready}, 64'd0);
         chk("calc_sum_held", sum, prev_sum);
         @(posedge clk);
         #1;
      end
      chk("calc_sum0_held", sum0, prev_sum0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_result();
      exp_t e;
      chk("out_valid_latency", {63'd0, out_valid}, 64'd1);
      chk("out_valid0_latency", {63'd0, out_valid0}, 64'd1);
      if (sb_q.size() == 0) begin
         errors++;
         checks++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
         e = sb_q.pop_front();
         chk("sum", sum, e.sum);
         chk("cout", {63'd0, cout}, {63'd0, e.cout});
         chk("ovf", {63'd0, ovf}, {63'd0, e.ovf});
         chk("nosub_sum", sum0, e.sum0);
         chk("nosub_cout", {63'd0, cout0}, {63'd0, e.cout0});
         chk("nosub_ovf", {63'd0, ovf0}, {63'd0, e.ovf0});
         prev_sum  = e.sum;
         prev_sum0 = e.sum0;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("released_out_valid", {63'd0, out_valid}, 64'd0);
      chk("released_in_ready", {63'd0, in_ready}, 64'd1);
      chk("released_sum_held", sum, prev_sum);
   endtask

   task automatic full_op(input logic [63:0] x, input logic [63:0] y, input logic ci,
                          input logic s, input logic [63:0] es, input logic ec,
                          input logic eo);
      start_op(x, y, ci, s, es, ec, eo);
      wait_calc();
      check_result();
      release_result();
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] rx;
      logic [63:0] ry;
      logic        rc;
      logic        rs;
      logic [65:0] rm;

      vecs[0] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'h0000_0000_0000_0000, 1'b1, 1'b0};
      vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vecs[3] = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      vecs[4] = '{64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      vecs[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      vecs[6] = '{64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0};
      vecs[7] = '{64'd0, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[8] = '{64'd9, 64'd9, 1'b0, 1'b1, 64'h0000_0000_0000_0000, 1'b1, 1'b0};

      clk       = 1'b0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = 64'd0;
      b         = 64'd0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b0;
      prev_sum  = 64'd0;
      prev_sum0 = 64'd0;

      // Reset state.
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_sum", sum, 64'd0);
      chk("rst_cout", {63'd0, cout}, 64'd0);
      chk("rst_ovf", {63'd0, ovf}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Idle with no request: nothing moves.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
         chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
         chk("idle_sum", sum, 64'd0);
      end

      // Directed table.
      for (int i = 0; i < 9; i++) begin
         full_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                 vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
      end

      // Random operations checked against the model.
      for (int i = 0; i < 6; i++) begin
         rx = {$urandom, $urandom};
         ry = {$urandom, $urandom};
         rc = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         rm = model(rx, ry, rc, rs);
         full_op(rx, ry, rc, rs, rm[63:0], rm[64], rm[65]);
      end

      // Back-pressure in DONE, then same-cycle handoff and accept.
      start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
               64'h2222_2222_2222_2211, 1'b0, 1'b0);
      wait_calc();
      check_result();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
         chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
         chk("bp_sum_stable", sum, 64'h2222_2222_2222_2211);
         chk("bp_cout_stable", {63'd0, cout}, 64'd0);
      end
      out_ready = 1'b1;
      start_op(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0,
               64'h0000_0000_0000_0000, 1'b1, 1'b0);
      chk("b2b_out_valid_dropped", {63'd0, out_valid}, 64'd0);
      chk("b2b_in_ready_calc", {63'd0, in_ready}, 64'd0);
      wait_calc();
      check_result();
      release_result();

      // Asynchronous reset after the second CALC beat aborts the operation.
      start_op(64'd100, 64'd23, 1'b0, 1'b0, 64'd123, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
      chk("abort_sum", sum, 64'd0);
      chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
      sb_q.delete();
      prev_sum  = 64'd0;
      prev_sum0 = 64'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("abort_recover_in_ready", {63'd0, in_ready}, 64'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("abort_no_result", {63'd0, out_valid}, 64'd0);
      end
      full_op(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0,
              64'hDEAD_BEF0_0000_0001, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lf_add64_seq.md
LF_ADD64_SEQ -- requirements
Module: lf_add64_seq

Interface
REQ-001 Parameter: SUB_EN, default 1, meaning 1 = sub input honoured, 0 = sub treated as 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block can accept operands this cycle.
REQ-006 a  input  64  operand A.
REQ-007 b  input  64  operand B.
REQ-008 cin  input  1  carry-in for add; ignored when sub effective.
REQ-009 sub  input  1  1 = compute a - b.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  64  result.
REQ-013 cout  output  1  carry out of bit 63.
REQ-014 ovf  output  1  two's-complement signed overflow.

Function
REQ-015 The block SHALL compute a 64-bit add or subtract over 4 beats on one shared 16-bit prefix (g,p) adder slice, chunk k = bits [16k+15:16k], k = 0..3, LSB chunk first.
REQ-016 FSM states SHALL be IDLE, CALC, DONE; a 2-bit beat counter SHALL index the chunk in CALC.
REQ-017 IDLE: in_ready = 1; on in_valid & in_ready the block SHALL capture a, b' (b' = ~b if sub effective else b), carry register = 1 if sub effective else cin, beat = 0, go to CALC.
REQ-018 CALC: each cycle the slice SHALL add a[chunk], b'[chunk] and the carry register, write the 16-bit sum into sum[chunk], load the chunk carry-out into the carry register and increment beat.
REQ-019 CALC with beat = 3 SHALL go to DONE, set cout = final carry, set ovf = carry into bit 63 XOR carry out of bit 63.
REQ-020 Latency: out_valid SHALL rise exactly 5 rising edges after the accepting edge, counting the accepting edge as edge 1. Accept on edge N; CALC beats on edges N+1..N+4; out_valid high after edge N+4.
REQ-021 DONE: out_valid = 1; sum, cout and ovf SHALL stay stable until out_valid & out_ready.
REQ-022 On out_valid & out_ready the block SHALL go to IDLE, unless a new request is also accepted that cycle.
REQ-023 in_ready SHALL equal (state == IDLE) OR (state == DONE AND out_ready). This allows back-to-back accept in the same cycle as result handoff, with next state CALC.
REQ-024 in_ready SHALL be 0 in CALC; a, b, cin and sub changes during CALC SHALL not affect the in-flight result.
REQ-025 in_valid deasserted in IDLE SHALL keep the state IDLE with outputs unchanged.
REQ-026 Wrap-around: results SHALL be modulo 2^64; cout reports the 2^64 carry; for subtract, cout = 1 means no borrow.
REQ-027 The intermediate chunk sums SHALL not be exposed on sum before out_valid; sum holds the previous result until DONE is reached.
REQ-028 With SUB_EN = 0, sub SHALL have no effect and cin SHALL always be used.

Reset
REQ-029 rst assertion SHALL immediately force IDLE, beat = 0, carry register = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0.
REQ-030 in_ready SHALL be 0 while rst is high and 1 from the first edge after deassertion.
REQ-031 Reset mid-CALC or in DONE SHALL abort the operation with no result delivered.

Verification
REQ-032 Add: a = 0x0000_0000_0000_FFFF, b = 1, cin = 0, sub = 0 -> after 5 edges sum = 0x0000_0000_0001_0000, cout = 0, ovf = 0; this proves the carry crosses chunk 0 to chunk 1.
REQ-033 Full ripple: a = 0xFFFF_FFFF_FFFF_FFFF, b = 0, cin = 1 -> sum = 0, cout = 1, ovf = 0.
REQ-034 Signed overflow: a = 0x7FFF_FFFF_FFFF_FFFF, b = 1, add -> sum = 0x8000_0000_0000_0000, ovf = 1, cout = 0. Subtract: a = 5, b = 7, sub = 1 -> sum = 0xFFFF_FFFF_FFFF_FFFE, cout = 0, ovf = 0.
REQ-035 Back-pressure and back-to-back: hold out_ready = 0 for 3 cycles in DONE -> outputs stable and in_ready = 0. Then raise out_ready with a new in_valid -> same-cycle accept, next result after 5 edges.
REQ-036 Reset: assert rst asynchronously after the 2nd CALC beat -> out_valid = 0 and sum = 0 immediately. After deassertion, in_ready = 1 and a fresh request completes correctly.
REQ-037 Operand change: change a and b every cycle during CALC -> result matches the operands captured at accept.
